// File: rtl/mmcu_sched.sv
// Issue sequencer for the 64-unit metric array: configuration, credit-based
// symbol issue, and the tag line that aligns valid/last/bps with array outputs.
module mmcu_sched #(
    parameter int WORDLENGTH = 18,
    parameter int FLEN_W     = 16,
    parameter int MCU_LAT    = 1,
    parameter int DS_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    input  logic [2:0]            cfg_mode,
    input  logic [FLEN_W-1:0]     cfg_frame_len,
    output logic                  cfg_ready,
    output logic                  cfg_err,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORDLENGTH-1:0] s_u_re,
    input  logic [WORDLENGTH-1:0] s_u_im,
    input  logic [WORDLENGTH-1:0] s_h,
    output logic [2:0]            mmcu_mode,
    output logic [WORDLENGTH-1:0] mmcu_u_re,
    output logic [WORDLENGTH-1:0] mmcu_u_im,
    output logic [WORDLENGTH-1:0] mmcu_h,
    output logic                  metric_valid,
    output logic                  metric_last,
    output logic [2:0]            metric_bps,
    input  logic                  ds_pop,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CRED_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              mode_q, mode_d;
    logic [FLEN_W-1:0]       flen_q, flen_d;
    logic [FLEN_W-1:0]       sym_cnt_q, sym_cnt_d;
    logic [CRED_W-1:0]       cred_q, cred_d;
    logic [WORDLENGTH-1:0]   u_re_q, u_re_d;
    logic [WORDLENGTH-1:0]   u_im_q, u_im_d;
    logic [WORDLENGTH-1:0]   h_q, h_d;
    logic                    cfg_err_q, cfg_err_d;
    logic [MCU_LAT:0]        tag_vld_q, tag_vld_d;
    logic [MCU_LAT:0]        tag_last_q, tag_last_d;
    logic [MCU_LAT:0][2:0]   tag_bps_q, tag_bps_d;

    logic issue;
    logic cfg_ok;
    logic is_last;

    assign s_ready      = (state_q == RUN) && (cred_q != '0) && (sym_cnt_q < flen_q);
    assign issue        = s_valid && s_ready;
    assign cfg_ok       = (cfg_mode >= 3'd1) && (cfg_mode <= 3'd5) && (cfg_frame_len != '0);
    assign is_last      = (sym_cnt_q == flen_q - FLEN_W'(1));

    assign cfg_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign cfg_err      = cfg_err_q;
    assign mmcu_mode    = mode_q;
    assign mmcu_u_re    = u_re_q;
    assign mmcu_u_im    = u_im_q;
    assign mmcu_h       = h_q;
    assign metric_valid = tag_vld_q[MCU_LAT];
    assign metric_last  = tag_last_q[MCU_LAT];
    assign metric_bps   = tag_bps_q[MCU_LAT];
    assign frame_done   = tag_vld_q[MCU_LAT] && tag_last_q[MCU_LAT];

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        flen_d    = flen_q;
        sym_cnt_d = sym_cnt_q;
        cfg_err_d = 1'b0;
        u_re_d    = u_re_q;
        u_im_d    = u_im_q;
        h_d       = h_q;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    if (cfg_ok) begin
                        mode_d    = cfg_mode;
                        flen_d    = cfg_frame_len;
                        sym_cnt_d = '0;
                        state_d   = RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    u_re_d    = s_u_re;
                    u_im_d    = s_u_im;
                    h_d       = s_h;
                    sym_cnt_d = sym_cnt_q + FLEN_W'(1);
                    if (is_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (frame_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop while the buffer is already fully credited is a no-op.
    always_comb begin
        cred_d = cred_q;
        if (issue && !ds_pop)
            cred_d = cred_q - CRED_W'(1);
        else if (ds_pop && !issue && (cred_q < CRED_W'(DS_DEPTH)))
            cred_d = cred_q + CRED_W'(1);
    end

    always_comb begin
        tag_vld_d     = tag_vld_q;
        tag_last_d    = tag_last_q;
        tag_bps_d     = tag_bps_q;
        tag_vld_d[0]  = issue;
        tag_last_d[0] = issue && is_last;
        tag_bps_d[0]  = issue ? (mode_q + 3'd1) : 3'd0;
        for (int i = 1; i <= MCU_LAT; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_last_d[i] = tag_last_q[i-1];
            tag_bps_d[i]  = tag_bps_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= 3'd1;
            flen_q     <= '0;
            sym_cnt_q  <= '0;
            cred_q     <= CRED_W'(DS_DEPTH);
            u_re_q     <= '0;
            u_im_q     <= '0;
            h_q        <= '0;
            cfg_err_q  <= 1'b0;
            tag_vld_q  <= '0;
            tag_last_q <= '0;
            tag_bps_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            flen_q     <= flen_d;
            sym_cnt_q  <= sym_cnt_d;
            cred_q     <= cred_d;
            u_re_q     <= u_re_d;
            u_im_q     <= u_im_d;
            h_q        <= h_d;
            cfg_err_q  <= cfg_err_d;
            tag_vld_q  <= tag_vld_d;
            tag_last_q <= tag_last_d;
            tag_bps_q  <= tag_bps_d;
        end
    end

endmodule

// File: tb/tb_mmcu_sched.sv
// Directed bench for mmcu_sched: config rejection, full-rate frame, credit
// exhaustion/saturation, ignored mid-frame config, async abort, frame_len 1.
module tb_mmcu_sched;

    localparam int WL = 18;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid;
    logic [2:0]    cfg_mode;
    logic [FW-1:0] cfg_frame_len;
    logic          cfg_ready, cfg_err;
    logic          s_valid, s_ready;
    logic [WL-1:0] s_u_re, s_u_im, s_h;
    logic [2:0]    mmcu_mode;
    logic [WL-1:0] mmcu_u_re, mmcu_u_im, mmcu_h;
    logic          metric_valid, metric_last;
    logic [2:0]    metric_bps;
    logic          ds_pop, busy, frame_done;

    int n_cmp = 0;
    int n_err = 0;

    mmcu_sched #(.WORDLENGTH(WL), .FLEN_W(FW), .MCU_LAT(1), .DS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_frame_len(cfg_frame_len),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_u_re(s_u_re), .s_u_im(s_u_im), .s_h(s_h),
        .mmcu_mode(mmcu_mode), .mmcu_u_re(mmcu_u_re), .mmcu_u_im(mmcu_u_im), .mmcu_h(mmcu_h),
        .metric_valid(metric_valid), .metric_last(metric_last), .metric_bps(metric_bps),
        .ds_pop(ds_pop), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sym(input int v);
        s_u_re = WL'(v);
        s_u_im = WL'(v + 1000);
        s_h    = WL'(v + 2000);
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_mode = 3'd0; cfg_frame_len = '0;
        s_valid = 1'b0; ds_pop = 1'b0; set_sym(0);
        tick(); tick();
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mode", mmcu_mode, 1);
        chk("rst_u_re", mmcu_u_re, 0);
        chk("rst_mvalid", metric_valid, 0);
        chk("rst_bps", metric_bps, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_fdone", frame_done, 0);
        rst_n = 1'b1;
        tick();

        // Rejected configurations
        cfg_valid = 1'b1; cfg_frame_len = 16'd8;
        cfg_mode = 3'd0; tick();
        chk("bad0_err", cfg_err, 1); chk("bad0_busy", busy, 0); chk("bad0_mode", mmcu_mode, 1);
        cfg_mode = 3'd6; tick();
        chk("bad6_err", cfg_err, 1); chk("bad6_busy", busy, 0); chk("bad6_mode", mmcu_mode, 1);
        cfg_mode = 3'd7; tick();
        chk("bad7_err", cfg_err, 1); chk("bad7_busy", busy, 0); chk("bad7_mode", mmcu_mode, 1);
        cfg_mode = 3'd3; cfg_frame_len = 16'd0; tick();
        chk("len0_err", cfg_err, 1); chk("len0_busy", busy, 0);
        cfg_valid = 1'b0; tick();
        chk("err_clear", cfg_err, 0);

        // Mode 5, 8 symbols, pop every cycle
        cfg_valid = 1'b1; cfg_mode = 3'd5; cfg_frame_len = 16'd8; tick();
        cfg_valid = 1'b0;
        chk("f1_busy", busy, 1); chk("f1_cfg_ready", cfg_ready, 0); chk("f1_mode", mmcu_mode, 5);
        s_valid = 1'b1; ds_pop = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            set_sym(100 + i);
            chk("f1_s_ready", s_ready, (i < 8) ? 1 : 0);
            tick();
            chk("f1_u_re", mmcu_u_re, 100 + ((i < 8) ? i : 7));
            chk("f1_u_im", mmcu_u_im, 1100 + ((i < 8) ? i : 7));
            chk("f1_h", mmcu_h, 2100 + ((i < 8) ? i : 7));
            chk("f1_mvalid", metric_valid, (i >= 1) ? 1 : 0);
            if (i >= 1) chk("f1_bps", metric_bps, 6);
            chk("f1_mlast", metric_last, (i == 8) ? 1 : 0);
            chk("f1_fdone", frame_done, (i == 8) ? 1 : 0);
        end
        s_valid = 1'b0; ds_pop = 1'b0; tick();
        chk("f1_idle_busy", busy, 0); chk("f1_idle_ready", cfg_ready, 1);
        chk("f1_idle_mvalid", metric_valid, 0); chk("f1_idle_fdone", frame_done, 0);

        // Mode 4, 10 symbols, no pops: credit exhaustion after 4
        cfg_valid = 1'b1; cfg_mode = 3'd4; cfg_frame_len = 16'd10; tick();
        s_valid = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            set_sym(400 + i);
            cfg_valid = (i == 2); cfg_mode = 3'd2; cfg_frame_len = 16'd3;
            chk("f2_s_ready", s_ready, (i < 4) ? 1 : 0);
            tick();
            chk("f2_cfg_err", cfg_err, 0);
            chk("f2_mode", mmcu_mode, 4);
            chk("f2_u_re", mmcu_u_re, 400 + ((i < 4) ? i : 3));
            chk("f2_mvalid", metric_valid, (i >= 1 && i <= 4) ? 1 : 0);
            if (i >= 1 && i <= 4) chk("f2_bps", metric_bps, 5);
        end
        cfg_valid = 1'b0;
        set_sym(404);
        ds_pop = 1'b1;
        chk("f2_pop_cycle_ready", s_ready, 0);
        tick();
        ds_pop = 1'b0;
        chk("f2_after_pop_ready", s_ready, 1);
        tick();
        chk("f2_one_more_ready", s_ready, 0);
        chk("f2_one_more_u_re", mmcu_u_re, 404);
        ds_pop = 1'b1; tick();
        chk("f2_cred1_ready", s_ready, 1);
        chk("f2_sym4_mvalid", metric_valid, 1);
        for (int j = 5; j <= 9; j++) begin
            set_sym(400 + j);
            chk("f2_popissue_ready", s_ready, 1);
            tick();
            chk("f2_popissue_mvalid", metric_valid, (j >= 6) ? 1 : 0);
            chk("f2_popissue_u_re", mmcu_u_re, 400 + j);
            chk("f2_popissue_mlast", metric_last, 0);
        end
        ds_pop = 1'b0; s_valid = 1'b0;
        chk("f2_drain_ready", s_ready, 0);
        chk("f2_drain_busy", busy, 1);
        tick();
        chk("f2_mlast", metric_last, 1); chk("f2_fdone", frame_done, 1); chk("f2_last_bps", metric_bps, 5);
        tick();
        chk("f2_idle_busy", busy, 0);

        // Credits 1 -> 4 with three pops; a fourth pop must saturate
        ds_pop = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        ds_pop = 1'b0;

        // Mode 2, 6 symbols, no pops: exactly 4 issues proves saturation
        cfg_valid = 1'b1; cfg_mode = 3'd2; cfg_frame_len = 16'd6; tick();
        cfg_valid = 1'b0;
        chk("f3_mode", mmcu_mode, 2);
        s_valid = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            set_sym(500 + i);
            chk("f3_s_ready", s_ready, (i < 4) ? 1 : 0);
            tick();
            chk("f3_mvalid", metric_valid, (i >= 1 && i <= 4) ? 1 : 0);
            if (i >= 1 && i <= 4) chk("f3_bps", metric_bps, 3);
        end
        ds_pop = 1'b1; tick();
        chk("f3_pop_ready", s_ready, 1);
        set_sym(600); tick();
        chk("f3_pi_ready", s_ready, 1);
        set_sym(601); tick();
        chk("f3_inflight_mvalid", metric_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_mvalid", metric_valid, 0);
        chk("ar_mlast", metric_last, 0);
        chk("ar_fdone", frame_done, 0);
        chk("ar_busy", busy, 0);
        chk("ar_cfg_ready", cfg_ready, 1);
        chk("ar_s_ready", s_ready, 0);
        chk("ar_mode", mmcu_mode, 1);
        chk("ar_u_re", mmcu_u_re, 0);
        chk("ar_bps", metric_bps, 0);
        chk("ar_cfg_err", cfg_err, 0);
        s_valid = 1'b0; ds_pop = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_mvalid", metric_valid, 0);
            chk("post_rst_fdone", frame_done, 0);
        end

        // Mode 1, 4 symbols, no pops: all 4 issue only if credits were restored
        cfg_valid = 1'b1; cfg_mode = 3'd1; cfg_frame_len = 16'd4; tick();
        cfg_valid = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_sym(700 + i);
            chk("f4_s_ready", s_ready, 1);
            tick();
        end
        s_valid = 1'b0;
        chk("f4_drain_ready", s_ready, 0);
        chk("f4_mvalid", metric_valid, 1);
        chk("f4_u_re", mmcu_u_re, 703);
        tick();
        chk("f4_mlast", metric_last, 1); chk("f4_fdone", frame_done, 1); chk("f4_bps", metric_bps, 2);
        tick();
        chk("f4_idle", busy, 0);

        // frame_len 1
        ds_pop = 1'b1; tick();
        ds_pop = 1'b0;
        cfg_valid = 1'b1; cfg_mode = 3'd3; cfg_frame_len = 16'd1; tick();
        cfg_valid = 1'b0;
        chk("f5_s_ready", s_ready, 1);
        s_valid = 1'b1; set_sym(800); tick();
        s_valid = 1'b0;
        chk("f5_drain_ready", s_ready, 0);
        chk("f5_busy", busy, 1);
        chk("f5_u_re", mmcu_u_re, 800);
        tick();
        chk("f5_mvalid", metric_valid, 1); chk("f5_mlast", metric_last, 1);
        chk("f5_fdone", frame_done, 1); chk("f5_bps", metric_bps, 4);
        tick();
        chk("f5_idle_busy", busy, 0); chk("f5_idle_ready", cfg_ready, 1); chk("f5_idle_mvalid", metric_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
